mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage between execute and wb_stage. Issues loads/stores to the data-memory
//  port through a req/ack handshake and aligns and extends load data. Registers the result
//  into core::pipeline_bus_t for wb_stage. Stalls upstream while an access is outstanding.
// PARAMETERS
//  MAX_WAIT  default 255  ack-wait cycles before the access is aborted and err_o is raised.
// PORTS
//  clk            in   1         clock; all state on posedge
//  rst            in   1         reset, asynchronous, active-low
//  bus_i          in   pipeline  from execute; rd_res = ALU result / effective address, rs2_val = store data
//  mem_bus_o      out  pipeline  registered bus to wb_stage.bus_i
//  mem_bp_o       out  bypass    {rd, rd_addr} of the mem_bus_o slot, combinational from mem_bus_o
//  stall_o        out  1         hold upstream stages
//  dmem_req_o     out  1         access request
//  dmem_we_o      out  1         1 = store
//  dmem_addr_o    out  32        word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata_o   out  32        store data, lane-replicated
//  dmem_be_o      out  4         byte enables
//  dmem_ack_i     in   1         one-cycle completion pulse; rdata valid with it
//  dmem_rdata_i   in   32        load word
//  misalign_o     out  1         1-cycle pulse: misaligned access squashed
//  err_o          out  1         1-cycle pulse: MAX_WAIT timeout
// BEHAVIOUR
//  - Clock and reset are fixed: one clock, clk; rst is asynchronous and active-low.
//  - Reset (rst=0, async):
//    - mem_bus_o = bubble: all bits 0, mem_op=MEM_NOP, alu_op=ALU_NOP, format=NOP, instr=I_NOP.
//    - FSM enters IDLE; the wait counter and every dmem_*/pulse output go to 0.
//  - FSM states:
//    - IDLE: bus_i.mem_op==MEM_NOP -> mem_bus_o<=bus_i next edge (latency 1), no request.
//    - IDLE: load/store, aligned -> go to REQ the same edge.
//    - IDLE: misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> mem_bus_o<=bubble, misalign_o=1, stay IDLE.
//    - REQ: dmem_req_o=1; addr/we/be/wdata held stable from registered copies of bus_i.
//    - REQ: dmem_ack_i=1 -> mem_bus_o<=captured bus with rd_res replaced (loads) -> IDLE.
//    - REQ: counter==MAX_WAIT and no ack -> mem_bus_o<=bubble, err_o=1 -> IDLE.
//    - REQ: ack on the same cycle as timeout -> ack wins.
//  - stall_o = (state==REQ) | (state==IDLE & bus_i.mem_op!=MEM_NOP & aligned).
//    - While stalling, mem_bus_o = bubble with pipeline_stall=1.
//    - The completing slot carries pipeline_stall=0.
//  - Byte enables and write data:
//    - SB: be = 1<<a[1:0], wdata = {4{rs2_val[7:0]}}.
//    - SH: be = 4'b0011<<a[1:0], wdata = {2{rs2_val[15:0]}}.
//    - SW: be = 4'hF.
//    - Loads: be = per-size mask, we=0.
//  - Load data:
//    - Select byte/half by a[1:0].
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//    - Result is 32 bits in rd_res.
//  - Stores write back rd_res unchanged, with rd=0 so there is no register write.
//  - Wait counter: 8-bit saturating; cleared on REQ entry; no wrap.
//  - Reset mid-access: the request drops asynchronously; the outstanding access is abandoned.
//    Any later ack while in IDLE is ignored.
// TESTING
//  1. ADD, rd=5, rd_res=0x11 -> next edge mem_bus_o.rd_res=0x11; no req; stall_o=0.
//  2. LB at 0x1003; rdata=0x80FF_FF00; ack after 3 cycles ->
//     be=4'b1000, stall_o=1 for 4 cycles, rd_res=0xFFFF_FF80.
//  3. SH at 0x2002; rs2_val=0xABCD1234 -> be=4'b1100, wdata=0x12341234, we=1.
//     On ack, mem_bus_o.rd=0.
//  4. LW at 0x3001 -> no req; misalign_o pulse; mem_bus_o=bubble; stall_o=0.
//  5. LHU at 0x4000 with no ack, MAX_WAIT=4 -> err_o pulse after 5 REQ cycles; return to IDLE.
//  6. rst low during REQ -> dmem_req_o=0 immediately; mem_bus_o=bubble.
//     A late ack after release has no effect.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage; req/ack dmem handshake, load align/extend,
// registered result bus to writeback, upstream stall while an access is in flight.
package core;
    typedef enum logic [3:0] {MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW} mem_op_t;
    typedef enum logic [3:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
    typedef enum logic [2:0] {NOP, FMT_R, FMT_I, FMT_S} format_t;
    typedef enum logic [3:0] {I_NOP, I_ALU, I_LOAD, I_STORE} instr_t;
    typedef struct packed {
        instr_t      instr;
        format_t     format;
        alu_op_t     alu_op;
        mem_op_t     mem_op;
        logic        rd;
        logic [4:0]  rd_addr;
        logic [31:0] rd_res;
        logic [31:0] rs2_val;
        logic        pipeline_stall;
    } pipeline_bus_t;
    typedef struct packed {
        logic       rd;
        logic [4:0] rd_addr;
    } bypass_t;
endpackage

module mem_stage import core::*; #(
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  pipeline_bus_t bus_i,
    output pipeline_bus_t mem_bus_o,
    output bypass_t       mem_bp_o,
    output logic          stall_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [31:0]   dmem_addr_o,
    output logic [31:0]   dmem_wdata_o,
    output logic [3:0]    dmem_be_o,
    input  logic          dmem_ack_i,
    input  logic [31:0]   dmem_rdata_i,
    output logic          misalign_o,
    output logic          err_o
);
    typedef enum logic {IDLE, REQ} state_t;
    localparam logic [7:0] MW = 8'(MAX_WAIT);
    localparam pipeline_bus_t BUBBLE = '0;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    pipeline_bus_t cap_q, out_q, bus_d, bub, fin;
    logic [31:0]   addr_q, wdata_q, wdata_d, sh_data, ld_data;
    logic [3:0]    be_q, be_d;
    logic          we_q, misal_q, err_q;
    logic [1:0]    a;
    logic          half_op, word_op, store_op, access, misal, start, timeout, cap_store;

    assign a        = bus_i.rd_res[1:0];
    assign half_op  = bus_i.mem_op inside {MEM_LH, MEM_LHU, MEM_SH};
    assign word_op  = bus_i.mem_op inside {MEM_LW, MEM_SW};
    assign store_op = bus_i.mem_op inside {MEM_SB, MEM_SH, MEM_SW};
    assign access   = bus_i.mem_op != MEM_NOP;
    assign misal    = access & ((half_op & a[0]) | (word_op & |a));
    assign timeout  = cnt_q == MW;
    assign start    = state_q == IDLE && state_d == REQ;
    assign be_d     = word_op ? 4'hF : half_op ? 4'b0011 << a : 4'b0001 << a;
    assign wdata_d  = word_op ? bus_i.rs2_val : half_op ? {2{bus_i.rs2_val[15:0]}} : {4{bus_i.rs2_val[7:0]}};

    // Load lane selection uses the address captured at request time, not the live bus.
    assign cap_store = cap_q.mem_op inside {MEM_SB, MEM_SH, MEM_SW};
    assign sh_data   = dmem_rdata_i >> {cap_q.rd_res[1:0], 3'b000};
    assign ld_data   = cap_q.mem_op == MEM_LB  ? {{24{sh_data[7]}}, sh_data[7:0]} :
                       cap_q.mem_op == MEM_LBU ? {24'b0, sh_data[7:0]} :
                       cap_q.mem_op == MEM_LH  ? {{16{sh_data[15]}}, sh_data[15:0]} :
                       cap_q.mem_op == MEM_LHU ? {16'b0, sh_data[15:0]} : dmem_rdata_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? ((access & ~misal) ? REQ : IDLE)
                                  : ((dmem_ack_i | timeout) ? IDLE : REQ);
    end

    always_comb begin
        bub = BUBBLE;
        bub.pipeline_stall = 1'b1;
        fin = cap_q;
        fin.pipeline_stall = 1'b0;
        fin.rd_res = cap_store ? cap_q.rd_res : ld_data;
        fin.rd = cap_store ? 1'b0 : cap_q.rd;
        bus_d = state_q == IDLE ? (!access ? bus_i : misal ? BUBBLE : bub)
                                : (dmem_ack_i ? fin : timeout ? BUBBLE : bub);
        cnt_d = start ? 8'd0 : (state_q == REQ && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            cap_q   <= BUBBLE;
            out_q   <= BUBBLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            misal_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            out_q   <= bus_d;
            misal_q <= state_q == IDLE && misal;
            err_q   <= state_q == REQ && !dmem_ack_i && timeout;
            if (start) begin
                cap_q   <= bus_i;
                addr_q  <= {bus_i.rd_res[31:2], 2'b00};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= store_op;
            end
        end
    end

    assign mem_bus_o        = out_q;
    assign mem_bp_o.rd      = out_q.rd;
    assign mem_bp_o.rd_addr = out_q.rd_addr;
    assign stall_o          = state_q == REQ || (state_q == IDLE && access && !misal);
    assign dmem_req_o       = state_q == REQ;
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wdata_o     = wdata_q;
    assign dmem_be_o        = be_q;
    assign misalign_o       = misal_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized transactions against an arithmetic reference model.
module tb_mem_stage;
    import core::*;
    localparam int MW = 4;
    logic clk = 1'b0, rst = 1'b0;
    pipeline_bus_t bus_i, mem_bus_o;
    bypass_t mem_bp_o;
    logic stall_o, dmem_req_o, dmem_we_o, dmem_ack_i, misalign_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0] dmem_be_o;
    int tests = 0, fails = 0;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .bus_i(bus_i), .mem_bus_o(mem_bus_o), .mem_bp_o(mem_bp_o),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chkbus(input string tag, input pipeline_bus_t obs, input pipeline_bus_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input mem_op_t op);
        if (op inside {MEM_LB, MEM_LBU, MEM_SB}) return 1;
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return 2;
        return 4;
    endfunction

    function automatic bit is_st(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic bit m_mis(input mem_op_t op, input logic [31:0] addr);
        return op != MEM_NOP && (addr % sz(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] addr);
        return 4'(((1 << sz(op)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_t op, input logic [31:0] rs2);
        if (sz(op) == 1) return 32'(rs2 % 256) * 32'h0101_0101;
        if (sz(op) == 2) return 32'(rs2 % 65536) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input mem_op_t op, input logic [31:0] addr, input logic [31:0] rdata);
        longint v, lim;
        v = longint'(rdata >> (8 * (addr % 4)));
        lim = longint'(1) << (8 * sz(op));
        v = v % lim;
        if (op inside {MEM_LB, MEM_LH} && v >= lim / 2) v -= lim;
        return 32'(v);
    endfunction

    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input logic [4:0] rda, input int ack_at);
        pipeline_bus_t b, exp;
        int stalls;
        bit acc, mis, acked;
        b = '0;
        b.instr = op == MEM_NOP ? I_ALU : is_st(op) ? I_STORE : I_LOAD;
        b.format = is_st(op) ? FMT_S : FMT_I;
        b.alu_op = ALU_ADD;
        b.mem_op = op;
        b.rd = !is_st(op);
        b.rd_addr = rda;
        b.rd_res = addr;
        b.rs2_val = rs2;
        acc = op != MEM_NOP;
        mis = m_mis(op, addr);
        bus_i = b;
        #1;
        chk("stall_in", 32'(stall_o), 32'(acc && !mis));
        stalls = int'(stall_o);
        @(negedge clk);
        if (!acc) begin
            chkbus("pass_bus", mem_bus_o, b);
            chk("pass_req", 32'(dmem_req_o), 32'd0);
        end else if (mis) begin
            chk("mis_pulse", 32'(misalign_o), 32'd1);
            chkbus("mis_bus", mem_bus_o, '0);
            chk("mis_req", 32'(dmem_req_o), 32'd0);
        end else begin
            chk("req", 32'(dmem_req_o), 32'd1);
            chk("addr", dmem_addr_o, addr & ~32'd3);
            chk("be", 32'(dmem_be_o), 32'(m_be(op, addr)));
            chk("we", 32'(dmem_we_o), 32'(is_st(op)));
            if (is_st(op)) chk("wdata", dmem_wdata_o, m_wdata(op, rs2));
            chk("stall_bub", 32'(mem_bus_o.pipeline_stall), 32'd1);
            acked = 0;
            for (int c = 1; c <= MW + 1; c++) begin
                chk("req_hold", 32'(dmem_req_o), 32'd1);
                stalls += int'(stall_o);
                dmem_rdata_i = $urandom;
                if (c == ack_at) begin
                    dmem_ack_i = 1'b1;
                    dmem_rdata_i = rdata;
                    acked = 1;
                end
                @(negedge clk);
                dmem_ack_i = 1'b0;
                if (acked) break;
            end
            if (acked) begin
                exp = b;
                exp.pipeline_stall = 1'b0;
                if (is_st(op)) exp.rd = 1'b0;
                else exp.rd_res = m_load(op, addr, rdata);
                chkbus("done_bus", mem_bus_o, exp);
                chk("bypass", 32'({mem_bp_o.rd, mem_bp_o.rd_addr}), 32'({exp.rd, exp.rd_addr}));
                chk("stall_cnt", 32'(stalls), 32'(ack_at + 1));
                chk("no_err", 32'(err_o), 32'd0);
            end else begin
                chk("err_pulse", 32'(err_o), 32'd1);
                chkbus("err_bus", mem_bus_o, '0);
                chk("err_stall_cnt", 32'(stalls), 32'(MW + 2));
            end
        end
        bus_i = '0;
        #1;
        chk("stall_idle", 32'(stall_o), 32'd0);
        chk("req_idle", 32'(dmem_req_o), 32'd0);
    endtask

    initial begin
        mem_op_t op;
        logic [31:0] addr;
        int ack_at;
        bus_i = '0;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        chkbus("rst_bus", mem_bus_o, '0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_pulses", 32'({misalign_o, err_o}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        run_op(MEM_NOP, 32'h11, $urandom, 0, 5'd5, 0);
        run_op(MEM_LB, 32'h1003, $urandom, 32'h80FF_FF00, 5'd7, 3);
        chk("lb_result", mem_bus_o.rd_res, 32'hFFFF_FF80);
        run_op(MEM_SH, 32'h2002, 32'hABCD_1234, $urandom, 5'd9, 2);
        run_op(MEM_LW, 32'h3001, $urandom, $urandom, 5'd3, 1);
        run_op(MEM_LHU, 32'h4000, $urandom, $urandom, 5'd4, 0);
        run_op(MEM_LW, 32'h4004, $urandom, 32'hCAFE_F00D, 5'd6, MW + 1);
        run_op(MEM_SB, 32'h4005, 32'h0000_00A5, $urandom, 5'd1, 1);
        run_op(MEM_LBU, 32'h4006, $urandom, 32'h0080_0000, 5'd2, 1);
        run_op(MEM_LH, 32'h4002, $urandom, 32'h8001_0000, 5'd8, 1);
        // Reset in the middle of an outstanding access, then a stray late ack.
        bus_i = '0;
        bus_i.mem_op = MEM_LW;
        bus_i.rd = 1'b1;
        bus_i.rd_addr = 5'd10;
        bus_i.rd_res = 32'h5000;
        @(negedge clk);
        chk("rst_mid_req_before", 32'(dmem_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req_o), 32'd0);
        chkbus("rst_mid_bus", mem_bus_o, '0);
        bus_i = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_ack_i = 1'b1;
        dmem_rdata_i = $urandom;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chkbus("late_ack_bus", mem_bus_o, '0);
        chk("late_ack_req", 32'(dmem_req_o), 32'd0);
        chk("late_ack_err", 32'(err_o), 32'd0);
        for (int i = 0; i < 60; i++) begin
            op = mem_op_t'($urandom_range(0, 8));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            ack_at = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, MW + 1);
            run_op(op, addr, $urandom, $urandom, 5'($urandom_range(1, 31)), ack_at);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
